mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_sat_ctr.sv | 19 +
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the instruction/data memory port arbiter.
package mem_arb_pkg;

   localparam int DEF_ADDR_W      = 32;
   localparam int DEF_DATA_W      = 32;
   localparam int DEF_MAX_DSTREAK = 4;
   localparam int STREAK_W        = 4;
   localparam int PERF_W          = 32;

   // Which port owns the read data returning from the RAM this cycle.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RD_IF = 2'd1,
      RD_D  = 2'd2
   } rd_state_e;

endpackage

// File: rtl/mem_arb_sat_ctr.sv
// Saturating up-counter with enable and synchronous clear.
module mem_arb_sat_ctr #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         en,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (clear) begin
         count <= '0;
      end else if (en && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one synchronous single-port RAM.
// Optional stall performance counters are enabled by defining MEM_ARB_PERF_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int MAX_DSTREAK = DEF_MAX_DSTREAK
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_if,
   output logic              stall_mem
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [PERF_W-1:0] perf_if_stall,
   output logic [PERF_W-1:0] perf_d_stall
`endif
);

   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);

   rd_state_e           state;
   rd_state_e           state_next;
   logic [STREAK_W-1:0] streak;
   logic                fetch_starved;
   logic                d_win;

   // Data normally wins; fetch is forced through once data has had its full streak.
   always_comb begin
      fetch_starved = if_req && (streak == STREAK_MAX);
      d_win         = d_req && !fetch_starved;
      d_gnt         = reset && d_win;
      if_gnt        = reset && if_req && !d_win;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         streak <= '0;
      end else if (if_gnt || !if_req) begin
         streak <= '0;
      end else if (d_gnt && (streak != STREAK_MAX)) begin
         streak <= streak + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = IDLE;
      if (if_gnt) begin
         state_next = RD_IF;
      end else if (d_gnt && !d_we) begin
         state_next = RD_D;
      end
   end

   always_comb begin
      if_rvalid = reset && (state == RD_IF);
      d_rvalid  = reset && (state == RD_D);
      if_rdata  = mem_rdata;
      d_rdata   = mem_rdata;
   end

   // Only the granted port's fields reach the RAM; idle cycles present zeros.
   always_comb begin
      mem_en    = if_gnt || d_gnt;
      mem_we    = d_gnt && d_we;
      mem_addr  = '0;
      mem_wdata = '0;
      if (d_gnt) begin
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
      end else if (if_gnt) begin
         mem_addr  = if_addr;
      end
      stall_if  = reset && if_req && !if_gnt;
      stall_mem = reset && d_req && !d_gnt;
   end

`ifdef MEM_ARB_PERF_EN
   mem_arb_sat_ctr #(.W(PERF_W)) u_perf_if (
      .clk   (clk),
      .clear (!reset),
      .en    (stall_if),
      .count (perf_if_stall)
   );

   mem_arb_sat_ctr #(.W(PERF_W)) u_perf_d (
      .clk   (clk),
      .clear (!reset),
      .en    (stall_mem),
      .count (perf_d_stall)
   );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a cycle-level reference model and a small saturating-counter check.
module tb_mem_port_arbiter;

   localparam int ADDR_W      = 32;
   localparam int DATA_W      = 32;
   localparam int MAX_DSTREAK = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              stall_if;
   logic              stall_mem;
`ifdef MEM_ARB_PERF_EN
   logic [31:0]       perf_if_stall;
   logic [31:0]       perf_d_stall;
`endif

   logic              sc_clear;
   logic              sc_en;
   logic [3:0]        sc_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .MAX_DSTREAK (MAX_DSTREAK)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_gnt     (d_gnt),
      .d_rvalid  (d_rvalid),
      .d_rdata   (d_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .stall_if  (stall_if),
      .stall_mem (stall_mem)
`ifdef MEM_ARB_PERF_EN
      ,
      .perf_if_stall (perf_if_stall),
      .perf_d_stall  (perf_d_stall)
`endif
   );

   mem_arb_sat_ctr #(.W(4)) u_sat (
      .clk   (clk),
      .clear (sc_clear),
      .en    (sc_en),
      .count (sc_count)
   );

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: arbitration by priority rules, read owner remembered as a pending return.
   int          m_streak = 0;
   int          m_pend   = 0;
   int          nx_streak = 0;
   int          nx_pend   = 0;
   logic [31:0] m_perf_if = 0;
   logic [31:0] m_perf_d  = 0;
   logic [31:0] nx_perf_if = 0;
   logic [31:0] nx_perf_d  = 0;

   always @(negedge clk) begin
      logic e_if, e_d, e_ifv, e_dv, e_sif, e_sd;
      logic [ADDR_W-1:0] e_addr;
      e_if = 0; e_d = 0; e_ifv = 0; e_dv = 0; e_sif = 0; e_sd = 0;
      e_addr = '0;
      if (!reset) begin
         nx_streak  = 0;
         nx_pend    = 0;
         nx_perf_if = 0;
         nx_perf_d  = 0;
      end else begin
         e_d   = d_req && !(if_req && m_streak == MAX_DSTREAK);
         e_if  = if_req && !e_d;
         e_ifv = (m_pend == 1);
         e_dv  = (m_pend == 2);
         e_sif = if_req && !e_if;
         e_sd  = d_req && !e_d;
         e_addr = e_d ? d_addr : if_addr;
         if (!if_req || e_if) nx_streak = 0;
         else if (e_d) nx_streak = (m_streak + 1 > MAX_DSTREAK) ? MAX_DSTREAK : m_streak + 1;
         else nx_streak = m_streak;
         nx_pend = e_if ? 1 : ((e_d && !d_we) ? 2 : 0);
         nx_perf_if = (e_sif && m_perf_if != 32'hFFFF_FFFF) ? m_perf_if + 1 : m_perf_if;
         nx_perf_d  = (e_sd  && m_perf_d  != 32'hFFFF_FFFF) ? m_perf_d  + 1 : m_perf_d;
      end
      checkOutput("m_if_gnt", if_gnt, e_if);
      checkOutput("m_d_gnt", d_gnt, e_d);
      checkOutput("m_mem_en", mem_en, e_if || e_d);
      checkOutput("m_mem_we", mem_we, e_d && d_we);
      if (e_if || e_d) checkOutput("m_mem_addr", mem_addr, e_addr);
      if (e_d && d_we) checkOutput("m_mem_wdata", mem_wdata, d_wdata);
      checkOutput("m_if_rvalid", if_rvalid, e_ifv);
      checkOutput("m_d_rvalid", d_rvalid, e_dv);
      if (e_ifv) checkOutput("m_if_rdata", if_rdata, mem_rdata);
      if (e_dv) checkOutput("m_d_rdata", d_rdata, mem_rdata);
      checkOutput("m_stall_if", stall_if, e_sif);
      checkOutput("m_stall_mem", stall_mem, e_sd);
`ifdef MEM_ARB_PERF_EN
      checkOutput("m_perf_if", perf_if_stall, m_perf_if);
      checkOutput("m_perf_d", perf_d_stall, m_perf_d);
`endif
   end

   always @(posedge clk) begin
      m_streak  <= nx_streak;
      m_pend    <= nx_pend;
      m_perf_if <= nx_perf_if;
      m_perf_d  <= nx_perf_d;
   end

   task automatic applyStimulus(input logic rst, input logic ir, input logic [ADDR_W-1:0] ia,
                                input logic dr, input logic dw, input logic [ADDR_W-1:0] da,
                                input logic [DATA_W-1:0] dwd, input logic [DATA_W-1:0] rd);
      @(posedge clk);
      #1;
      reset     = rst;
      if_req    = ir;
      if_addr   = ia;
      d_req     = dr;
      d_we      = dw;
      d_addr    = da;
      d_wdata   = dwd;
      mem_rdata = rd;
      @(negedge clk);
      #1;
   endtask

   initial begin
      reset = 0; if_req = 1; if_addr = '0; d_req = 1; d_we = 0;
      d_addr = '0; d_wdata = '0; mem_rdata = '0;
      sc_clear = 1; sc_en = 0;

      // Reset holds everything quiet even with both requests high.
      applyStimulus(0, 1, 32'h4, 1, 0, 32'h8, 0, 32'h1);
      applyStimulus(0, 1, 32'h4, 1, 0, 32'h8, 0, 32'h1);
      checkOutput("rst_if_gnt", if_gnt, 0);
      checkOutput("rst_d_gnt", d_gnt, 0);
      checkOutput("rst_mem_en", mem_en, 0);
      checkOutput("rst_stall_if", stall_if, 0);
      checkOutput("rst_stall_mem", stall_mem, 0);

      // Lone fetch and its read return.
      applyStimulus(1, 1, 32'h10, 0, 0, 0, 0, 32'hDEADBEEF);
      checkOutput("fetch_gnt", if_gnt, 1);
      checkOutput("fetch_addr", mem_addr, 32'h10);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF);
      checkOutput("fetch_rvalid", if_rvalid, 1);
      checkOutput("fetch_rdata", if_rdata, 32'hDEADBEEF);

      // Contention: data read wins, fetch granted back-to-back with the data return.
      applyStimulus(1, 1, 32'h30, 1, 0, 32'h20, 0, 32'h0);
      checkOutput("cont_d_gnt", d_gnt, 1);
      checkOutput("cont_stall_if", stall_if, 1);
      checkOutput("cont_addr", mem_addr, 32'h20);
      applyStimulus(1, 1, 32'h30, 0, 0, 0, 0, 32'hCAFE0020);
      checkOutput("cont_d_rvalid", d_rvalid, 1);
      checkOutput("cont_if_rvalid", if_rvalid, 0);
      checkOutput("b2b_if_gnt", if_gnt, 1);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 32'hCAFE0030);
      checkOutput("b2b_if_rvalid", if_rvalid, 1);

      // Data streak limit forces one fetch through.
      for (int i = 1; i <= 6; i++) begin
         applyStimulus(1, 1, 32'h100, 1, 0, 32'h200 + i, 0, 32'h5A5A0000 + i);
         checkOutput($sformatf("streak_c%0d_d_gnt", i), d_gnt, (i != 5));
         checkOutput($sformatf("streak_c%0d_if_gnt", i), if_gnt, (i == 5));
      end

      // Store: write strobes, no read return afterwards.
      applyStimulus(1, 0, 0, 1, 1, 32'h40, 32'h12345678, 0);
      checkOutput("store_we", mem_we, 1);
      checkOutput("store_wdata", mem_wdata, 32'h12345678);
      checkOutput("store_addr", mem_addr, 32'h40);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 32'hFFFF0000);
      checkOutput("store_no_rvalid", d_rvalid, 0);

      // Build a streak, reset right after a read grant, then confirm clean restart.
      applyStimulus(1, 1, 32'h300, 1, 0, 32'h400, 0, 0);
      applyStimulus(1, 1, 32'h300, 1, 0, 32'h404, 0, 0);
      applyStimulus(1, 1, 32'h300, 1, 0, 32'h408, 0, 0);
      checkOutput("pre_rst_d_gnt", d_gnt, 1);
      applyStimulus(0, 1, 32'h300, 1, 0, 32'h40C, 0, 32'h77);
      checkOutput("mid_rst_d_rvalid", d_rvalid, 0);
      checkOutput("mid_rst_d_gnt", d_gnt, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 32'h77);
      checkOutput("post_rst_d_rvalid", d_rvalid, 0);
      checkOutput("post_rst_if_rvalid", if_rvalid, 0);
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(1, 1, 32'h500, 1, 0, 32'h600, 0, 0);
         checkOutput($sformatf("restreak_c%0d_d_gnt", i), d_gnt, (i != 5));
`ifdef MEM_ARB_PERF_EN
         if (i == 4) checkOutput("perf_if_three", perf_if_stall, 32'd3);
`endif
      end

      // Mixed traffic patterns, checked by the model only.
      for (int i = 0; i < 24; i++) begin
         applyStimulus(1, ((i % 3) != 1), 32'h800 + 4 * i, ((i % 4) != 0), ((i % 5) == 2),
                       32'h900 + 4 * i, 32'hA000 + i, 32'hB000 + i);
      end
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);

      // Saturating counter: counts enabled cycles, then sticks at all-ones.
      @(posedge clk); #1;
      sc_clear = 0; sc_en = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("sat_count3", sc_count, 4'd3);
      repeat (20) @(posedge clk);
      @(negedge clk);
      checkOutput("sat_max", sc_count, 4'hF);
      sc_en = 0; sc_clear = 1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("sat_clear", sc_count, 4'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
